// File: rtl/dualmem_pkg.sv
// Shared types and helpers for the lane-granular dual-port RAM request front end.
// Byte masks are folded onto the RAM's 32-bit lane write enables here.
package dualmem_pkg;

    localparam int ADDR_W         = 9;
    localparam int DATA_W         = 64;
    localparam int LANE_W         = 32;
    localparam int BE_W           = DATA_W / 8;
    localparam int LANES          = DATA_W / LANE_W;
    localparam int BYTES_PER_LANE = LANE_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_READ = 2'd0,
        KIND_FULL = 2'd1,
        KIND_RMW  = 2'd2,
        KIND_NONE = 2'd3
    } kind_t;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic [BE_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [BE_W-1:0] mask;
        for (int l = 0; l < LANES; l++) begin
            mask[l*BYTES_PER_LANE +: BYTES_PER_LANE] =
                {BYTES_PER_LANE{|be[l*BYTES_PER_LANE +: BYTES_PER_LANE]}};
        end
        return mask;
    endfunction

    // A lane that is touched but not fully enabled cannot be written directly.
    function automatic logic lane_partial(input logic [BE_W-1:0] be);
        logic partial;
        partial = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if ((|be[l*BYTES_PER_LANE +: BYTES_PER_LANE]) &&
                !(&be[l*BYTES_PER_LANE +: BYTES_PER_LANE])) begin
                partial = 1'b1;
            end else begin
                partial = partial;
            end
        end
        return partial;
    endfunction

    function automatic kind_t classify(input logic we, input logic [BE_W-1:0] be);
        kind_t kind;
        if (!we) begin
            kind = KIND_READ;
        end else if (be == {BE_W{1'b0}}) begin
            kind = KIND_NONE;
        end else if (lane_partial(be)) begin
            kind = KIND_RMW;
        end else begin
            kind = KIND_FULL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/dualmem_rmw_port.sv
// Request front end for one port of the 512x64 block RAM: single-beat byte-masked
// reads/writes, with partial-lane writes expanded into read-modify-write sequences.
module dualmem_rmw_port #(
    parameter int ADDR_W = dualmem_pkg::ADDR_W,
    parameter int DATA_W = dualmem_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic [7:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [CNT_W-1:0]  rmw_count
);

    import dualmem_pkg::*;

    state_t              state_r;
    kind_t               kind_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                mem_en_r;
    logic [7:0]          mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_din_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [7:0]          be_r;
    logic [CNT_W-1:0]    rmw_count_r;
    kind_t               req_kind_s;

    assign req_kind_s = classify(req_we, req_be);

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign rmw_count = rmw_count_r;

    // Request/response FSM with all RAM-side and handshake outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            kind_r      <= KIND_READ;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            mem_en_r    <= 1'b0;
            mem_we_r    <= 8'h00;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_din_r   <= {DATA_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            be_r        <= 8'h00;
            rmw_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 8'h00;
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        kind_r      <= req_kind_s;
                        mem_addr_r  <= req_addr;
                        wdata_r     <= req_wdata;
                        be_r        <= req_be;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        case (req_kind_s)
                            KIND_NONE: begin
                                rsp_valid_r <= 1'b1;
                                state_r     <= ST_RESP;
                            end
                            KIND_FULL: begin
                                mem_en_r  <= 1'b1;
                                mem_we_r  <= lane_mask(req_be);
                                mem_din_r <= req_wdata;
                                state_r   <= ST_ACCESS;
                            end
                            default: begin
                                // Reads and RMW both start with a plain RAM read.
                                mem_en_r <= 1'b1;
                                mem_we_r <= 8'h00;
                                state_r  <= ST_ACCESS;
                            end
                        endcase
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 8'h00;
                    if (kind_r == KIND_FULL) begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (kind_r == KIND_RMW) begin
                        mem_en_r  <= 1'b1;
                        mem_we_r  <= lane_mask(be_r);
                        mem_din_r <= byte_merge(wdata_r, mem_dout, be_r);
                        state_r   <= ST_WRITE;
                    end else begin
                        rsp_rdata_r <= mem_dout;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    mem_en_r    <= 1'b0;
                    mem_we_r    <= 8'h00;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                    if (rmw_count_r != {CNT_W{1'b1}}) begin
                        rmw_count_r <= rmw_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        rmw_count_r <= rmw_count_r;
                    end
                end
                ST_RESP: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 8'h00;
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    mem_en_r    <= 1'b0;
                    mem_we_r    <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dualmem_rmw_port.sv
// Self-checking bench for dualmem_rmw_port: behavioural RAM, reference word image,
// and a queue of expected responses checked as the DUT returns them.
module tb_dualmem_rmw_port;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [8:0]  mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;
    logic [15:0] rmw_count;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    logic [63:0] ref_mem[0:511];
    logic [15:0] exp_cnt;

    logic [63:0] ram[0:511];
    logic [511:0] written = '0;

    dualmem_rmw_port #(.ADDR_W(9), .DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .rmw_count(rmw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [8:0] a);
        if (a == 9'h012) return 64'h0123_4567_89AB_CDEF;
        if (a == 9'h005) return 64'h1111_1111_2222_2222;
        return {32'h9E37_79B1 ^ {23'd0, a}, 32'h7F4A_7C15 + {23'd0, a}};
    endfunction

    // Behavioural RAM port: byte write enables, read data one cycle after an enabled read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 8'h00) begin
                mem_dout <= written[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    ram[mem_addr][8*i +: 8] <= mem_we[i] ? mem_din[8*i +: 8]
                        : (written[mem_addr] ? ram[mem_addr][8*i +: 8] : init_word(mem_addr) >> (8*i));
                end
                written[mem_addr] <= 1'b1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_value({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_req(input string tag, input logic we, input logic [8:0] addr,
                           input logic [63:0] wdata, input logic [7:0] be, input int hold);
        logic [63:0] merged, exp_rd, exp_din, seen_din, got_rd;
        logic [7:0]  exp_we, seen_we;
        logic [1:0]  touched, full;
        logic        is_rmw, got;
        int          exp_lat, exp_en, en_cnt, addr_bad, cyc;

        merged = ref_mem[addr];
        for (int i = 0; i < 8; i++) if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        touched = {|be[7:4], |be[3:0]};
        full    = {&be[7:4], &be[3:0]};
        is_rmw  = we && |(touched & ~full);
        exp_we  = {{4{touched[1]}}, {4{touched[0]}}};
        exp_din = 64'd0;
        if (!we) begin
            exp_lat = 3; exp_en = 1; exp_we = 8'h00; exp_rd = ref_mem[addr];
        end else if (be == 8'h00) begin
            exp_lat = 1; exp_en = 0; exp_rd = 64'd0;
        end else if (is_rmw) begin
            exp_lat = 4; exp_en = 2; exp_rd = 64'd0; exp_din = merged;
        end else begin
            exp_lat = 2; exp_en = 1; exp_rd = 64'd0; exp_din = wdata;
        end

        rsp_ready = (hold == 0);
        wait_ready(tag);
        exp_q.push_back(exp_rd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;

        cyc = 1; got = 1'b0; en_cnt = 0; addr_bad = 0; seen_we = 8'h00; seen_din = 64'd0;
        while (cyc <= 10 && !got) begin
            if (mem_en) begin
                en_cnt++;
                if (mem_addr !== addr) addr_bad++;
                if (mem_we != 8'h00) begin seen_we = mem_we; seen_din = mem_din; end
            end
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        got_rd = exp_q.pop_front();
        if (!got) begin
            check_value({tag, "_rsp_timeout"}, 64'd0, 64'd1);
            return;
        end
        check_value({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_value({tag, "_rdata"}, rsp_rdata, got_rd);
        check_value({tag, "_en_pulses"}, 64'(en_cnt), 64'(exp_en));
        check_value({tag, "_mem_we"}, 64'(seen_we), 64'(exp_we));
        check_value({tag, "_addr"}, 64'(addr_bad), 64'd0);
        if (exp_we != 8'h00) check_value({tag, "_mem_din"}, seen_din, exp_din);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_value({tag, "_hold_ctl"}, {61'd0, rsp_valid, req_ready, mem_en}, 64'b100);
            check_value({tag, "_hold_rdata"}, rsp_rdata, got_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_value({tag, "_after_hs"}, {62'd0, rsp_valid, req_ready}, 64'b01);

        if (is_rmw && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        check_value({tag, "_rmw_count"}, 64'(rmw_count), 64'(exp_cnt));
        if (we) ref_mem[addr] = merged;
    endtask

    initial begin
        int cyc;
        logic [7:0] be_tab[4];
        checks = 0; errors = 0; exp_cnt = 16'd0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(9'(i));
        be_tab[0] = 8'h00; be_tab[1] = 8'hFF; be_tab[2] = 8'h0F; be_tab[3] = 8'h3C;
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 9'd0;
        req_wdata = 64'd0; req_be = 8'h00; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready", 64'(req_ready), 64'd0);
        check_value("rst_outs", {rsp_valid, mem_en, mem_we, mem_addr, 16'd0},
                    64'd0);
        check_value("rst_data", rsp_rdata | mem_din | 64'(rmw_count), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_value("rel_ready", 64'(req_ready), 64'd1);

        run_req("rd012", 1'b0, 9'h012, 64'd0, 8'h00, 0);
        run_req("wr1ff", 1'b1, 9'h1FF, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0);
        run_req("rb1ff", 1'b0, 9'h1FF, 64'd0, 8'h00, 0);
        check_value("rb1ff_upper", {32'd0, ref_mem[9'h1FF][63:32]}, 64'h0000_0000_DEAD_BEEF);
        run_req("rmw005", 1'b1, 9'h005, 64'h0000_0000_00AB_CD00, 8'h06, 0);
        run_req("rb005", 1'b0, 9'h005, 64'd0, 8'h00, 0);
        run_req("wr_be0", 1'b1, 9'h007, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
        run_req("rd_hold", 1'b0, 9'h012, 64'd0, 8'h00, 5);
        run_req("b2b_rmw", 1'b1, 9'h012, 64'h5555_6666_7777_8888, 8'h81, 0);

        for (int k = 0; k < 12; k++) begin
            logic [8:0]  a;
            logic [7:0]  b;
            a = 9'($urandom_range(0, 15));
            b = (k % 2 == 0) ? be_tab[k % 4] : 8'($urandom);
            run_req("rnd_wr", 1'b1, a, {$urandom, $urandom}, b, 0);
            run_req("rnd_rd", 1'b0, a, 64'd0, 8'h00, k % 3);
        end

        // Reset in the WRITE cycle of an RMW must kill the write and the response.
        rsp_ready = 1'b1;
        wait_ready("rst_rmw");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h0A0; req_wdata = 64'h1234; req_be = 8'h01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (mem_we == 8'h00 && cyc < 10) begin @(posedge clk); #1; cyc++; end
        check_value("rst_write_cycle", 64'(cyc), 64'd3);
        rstn = 1'b0;
        #1;
        check_value("rst_mid_ctl", {55'd0, mem_en, mem_we}, 64'd0);
        check_value("rst_mid_rsp", {62'd0, rsp_valid, req_ready}, 64'd0);
        check_value("rst_mid_cnt", 64'(rmw_count), 64'd0);
        exp_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_no_rsp", 64'(rsp_valid), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_value("rst_rel_ready", {62'd0, req_ready, rsp_valid}, 64'b10);
        run_req("post_rst_rd", 1'b0, 9'h005, 64'd0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dualmem_rmw_port.md
# dualmem_rmw_port

Request-side front end for one port of the 512×64 dual-port block RAM, which only honours write enables at 32-bit lane granularity. Accepts single-beat read/write requests carrying an 8-bit byte mask and converts partial-lane writes into read-modify-write sequences. Full-lane writes pass straight through. Sits directly upstream of the RAM port; every request returns exactly one response.

## Interface
- ADDR_W, 9, word address width (512 × 64-bit words)
- DATA_W, 64, data width; fixed at 64 (two 32-bit lanes)
- CNT_W, 16, width of the RMW event counter
- clk  in  1  clock; drives the RAM port clock as well
- rstn  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  8  byte enables; bit i covers bits 8i+7:8i
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- mem_en  out  1  RAM port enable
- mem_we  out  8  RAM write enable; bits 3:0 replicate lane 0, bits 7:4 replicate lane 1
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data, valid the cycle after an enabled read
- rmw_count  out  CNT_W  saturating count of RMW sequences completed

## Operation
- States: IDLE, ACCESS, CAPTURE, WRITE, RESP. req_ready = 1 only in IDLE.
- Lane L is "touched" if req_be[4L+3:4L] ≠ 0. It is "full" if req_be[4L+3:4L] = 4'hF.
- Accept in IDLE, then classify the request:
  - Read: to ACCESS with mem_en = 1, mem_we = 0.
  - Write, be = 0: no RAM access; to RESP.
  - Write, every touched lane is full: to ACCESS with mem_en = 1, mem_we lanes = touched lanes, mem_din = req_wdata; then to RESP.
  - Write, any touched lane is partial (RMW): to ACCESS as a read.
- ACCESS then goes to CAPTURE for reads and RMW.
- CAPTURE:
  - Read: latch mem_dout into rsp_rdata; go to RESP.
  - RMW: merged byte i = be[i] ? wdata byte i : mem_dout byte i. Register mem_en = 1, mem_we lanes = touched lanes, mem_din = merged. Go to WRITE.
- WRITE: the RAM write happens. Increment rmw_count, saturating at all-ones. Go to RESP.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_ready; on handshake go to IDLE.
- Address, wdata and be are latched at accept; request inputs are ignored afterwards.
- Memory-side outputs are registered. mem_en and mem_we are 0 in every state except ACCESS and WRITE.
- Port B writes to the same address during an RMW window (ACCESS through WRITE) are not detected. Coherence is the system's responsibility.

## Timing
- Reset values: req_ready = 0 while rstn is low and 1 in the first cycle after release. All other outputs are 0: rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_din, rmw_count. FSM = IDLE.
- With the accept edge ending cycle 0, rsp_valid first asserts in:
  - be = 0 write: cycle 1.
  - Full-lane write: cycle 2.
  - Read: cycle 3.
  - RMW: cycle 4.
- One request is outstanding at a time. The next accept is possible in the cycle after the rsp handshake.
- The rsp handshake occurs on the first edge with rsp_valid & rsp_ready. A zero-wait consumer sees rsp_valid for exactly one cycle.
- If rstn asserts mid-sequence, all outputs clear immediately, the request is dropped and no response is issued. If this happens in WRITE, the target word's content is undefined.
- rmw_count holds at 2^CNT_W−1 once saturated.

## Structure
- Shared package dualmem_pkg holds:
  - ADDR_W, DATA_W and LANE_W = 32.
  - The state enum type.
  - A byte-merge function (wdata, rdata, be → merged).
  - A lane-mask function (be → 8-bit mem_we).
- No sub-module; a single FSM plus datapath registers.

## Test plan
- Read at addr 0x012, RAM preloaded with 0x0123_4567_89AB_CDEF -> rsp_valid at cycle 3, rsp_rdata = 0x0123_4567_89AB_CDEF, mem_we = 0 throughout.
- Write addr 0x1FF, be = 0xF0, wdata = 0xDEAD_BEEF_0000_0000 -> single ACCESS cycle with mem_we = 0xF0, rsp at cycle 2, rmw_count unchanged, read-back upper lane = 0xDEAD_BEEF.
- Word 0x005 = 0x1111_1111_2222_2222; write be = 0x06, wdata = 0x0000_0000_00AB_CD00 -> read then write, mem_we = 0x0F, mem_din = 0x1111_1111_22AB_CD22, rsp at cycle 4, rmw_count = 1.
- Write be = 0x00 -> no mem_en pulse, rsp at cycle 1.
- Hold rsp_ready low for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready = 0. Then raise rsp_ready -> back-to-back request accepted the next cycle.
- Assert rstn low during WRITE of an RMW -> mem_en/mem_we drop in the same cycle, no rsp; after release req_ready = 1 and a fresh read completes normally.
